reg_file: RTL and testbench

- Multi-ported register bank built from per-bit storage of the same kind as the team's D flip-flop cell.
- Sits directly downstream of the single-bit DFF stage: it aggregates DFF-style storage into a word-addressed array.
- Feeds the datapath: one synchronous write port, two asynchronous read ports.
- Used as the CPU register file in the lab datapath.

---
 rtl/reg_file.sv | 61 ++++++
 tb/tb_reg_file.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Word-addressed register bank: one clocked write port, two combinational read ports.
// Optional hardwired zero register and write-to-read forwarding.
`timescale 1ns/1ps
module reg_file #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [WIDTH-1:0]  rd2
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wa_zero;
   logic             wr_ok;

   assign wa_zero = (ZERO_REG != 0) && (wa == '0);
   assign wr_ok   = we && !wa_zero;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wa] <= wd;
      end
   end

   // Zero-register and reset masking applied last so they override forwarding
   always_comb begin
      rd1 = mem[ra1];
      if ((BYPASS != 0) && wr_ok && (wa == ra1)) begin
         rd1 = wd;
      end
      if (clr || ((ZERO_REG != 0) && (ra1 == '0))) begin
         rd1 = '0;
      end
   end

   always_comb begin
      rd2 = mem[ra2];
      if ((BYPASS != 0) && wr_ok && (wa == ra2)) begin
         rd2 = wd;
      end
      if (clr || ((ZERO_REG != 0) && (ra2 == '0))) begin
         rd2 = '0;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: default build plus no-zero-reg
// and no-bypass variants sharing one stimulus stream.
`timescale 1ns/1ps
module tb_reg_file;

   logic        clk = 1'b0;
   logic        clr;
   logic        we;
   logic [2:0]  wa;
   logic [31:0] wd;
   logic [2:0]  ra1;
   logic [2:0]  ra2;
   logic [31:0] a1, a2, z1, z2, b1, b2;

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   reg_file #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(a1), .rd2(a2)
   );

   reg_file #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_nz (
      .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(z1), .rd2(z2)
   );

   reg_file #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_nb (
      .clk(clk), .clr(clr), .we(we), .wa(wa), .wd(wd),
      .ra1(ra1), .ra2(ra2), .rd1(b1), .rd2(b2)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      sb.push_back(v);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (sb.size() == 0) begin
         $display("scoreboard empty at %s", tag);
         e = ~obs;
      end else begin
         e = sb.pop_front();
      end
      chk(tag, obs, e);
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we = 1'b1;
      wa = a;
      wd = d;
      edge_step();
      we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] v;
      clr = 1'b1;
      we  = 1'b0;
      wa  = '0;
      wd  = '0;
      ra1 = 3'd3;
      ra2 = 3'd5;
      #2;
      push(32'h0); push(32'h0); push(32'h0);
      pop_chk("rst_rd1", a1);
      pop_chk("rst_rd2", a2);
      pop_chk("rst_nz_rd1", z1);
      @(negedge clk);
      clr = 1'b0;

      // reset clears between edges
      wr(3'd3, 32'hA5A5A5A5);
      push(32'hA5A5A5A5);
      pop_chk("t1_written", a1);
      #1 clr = 1'b1;
      #1;
      push(32'h0);
      pop_chk("t1_async_clr", a1);
      clr = 1'b0;
      edge_step();
      push(32'h0);
      pop_chk("t1_after_edge", a1);

      // write / read
      wr(3'd5, 32'h12345678);
      wr(3'd6, 32'hDEADBEEF);
      ra1 = 3'd5;
      ra2 = 3'd6;
      for (int i = 0; i < 4; i++) begin
         #1;
         push(32'h12345678); push(32'hDEADBEEF);
         pop_chk("t2_rd1", a1);
         pop_chk("t2_rd2", a2);
         edge_step();
      end

      // zero register
      wr(3'd0, 32'hFFFFFFFF);
      ra1 = 3'd0;
      ra2 = 3'd0;
      #1;
      push(32'h0); push(32'h0);
      push(32'hFFFFFFFF); push(32'hFFFFFFFF);
      pop_chk("t3_zero_rd1", a1);
      pop_chk("t3_zero_rd2", a2);
      pop_chk("t3_nz_rd1", z1);
      pop_chk("t3_nz_rd2", z2);
      we = 1'b1;
      wa = 3'd0;
      wd = 32'h5555AAAA;
      #1;
      push(32'h0); push(32'h5555AAAA);
      pop_chk("t3_zero_bypass", a1);
      pop_chk("t3_nz_bypass", z1);
      we = 1'b0;

      // bypass
      wr(3'd2, 32'h1);
      ra1 = 3'd2;
      we  = 1'b1;
      wa  = 3'd2;
      wd  = 32'h99;
      #1;
      push(32'h99); push(32'h1);
      pop_chk("t4_byp_pre", a1);
      pop_chk("t4_nobyp_pre", b1);
      edge_step();
      push(32'h99); push(32'h99);
      pop_chk("t4_byp_post", a1);
      pop_chk("t4_nobyp_post", b1);
      we = 1'b0;

      // reset beats write
      @(negedge clk);
      clr = 1'b1;
      we  = 1'b1;
      wa  = 3'd4;
      wd  = 32'h77;
      ra1 = 3'd4;
      #1;
      push(32'h0);
      pop_chk("t5_clr_masks_byp", a1);
      edge_step();
      clr = 1'b0;
      we  = 1'b0;
      #1;
      push(32'h0);
      pop_chk("t5_no_write", a1);
      wr(3'd4, 32'h77);
      push(32'h77);
      pop_chk("t5_write_after", a1);

      // dual port same address and sweep
      wr(3'd7, 32'hCAFE0000);
      ra1 = 3'd7;
      ra2 = 3'd7;
      #1;
      push(32'hCAFE0000); push(32'hCAFE0000);
      pop_chk("t6_same_rd1", a1);
      pop_chk("t6_same_rd2", a2);
      for (int a = 0; a < 8; a++) begin
         wr(3'(a), 32'(a) * 32'h11111111);
      end
      for (int a = 0; a < 8; a++) begin
         ra1 = 3'(a);
         ra2 = 3'(a);
         v = 32'(a) * 32'h11111111;
         #1;
         push((a == 0) ? 32'h0 : v);
         push((a == 0) ? 32'h0 : v);
         push(v);
         push(v);
         pop_chk("t6_sweep_rd1", a1);
         pop_chk("t6_sweep_rd2", a2);
         pop_chk("t6_sweep_nz_rd1", z1);
         pop_chk("t6_sweep_nz_rd2", z2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
